sst_engine: RTL and testbench

SST_ENGINE -- requirements
Module: sst_engine

---
 rtl/sst_engine.sv | 181 ++++++++++++++++++
 tb/tb_sst_engine.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sst_engine.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// sst_engine
// Moves a mapper's save-state image to and from a host byte stream.
//   Save    (cmd_dir=0): reads mapper addr 127 (index), then 0..126, and
//                        streams 128 bytes out over out_valid/out_ready.
//   Restore (cmd_dir=1): reads the mapper index, checks it against the first
//                        host byte, then writes host bytes 1..127 into mapper
//                        addr 0..126. A header mismatch sets err and writes
//                        nothing.
//
// Ports
//   clk, rst_n            system clock, async active-low reset
//   cmd_start, cmd_dir    command pulse and direction (sampled when idle)
//   sst_act               mapper save-state mode, high while busy
//   sst_addr/sst_we/sst_do/sst_di   mapper register port (1-cycle read latency)
//   out_valid/out_ready/out_data    save stream
//   in_valid/in_ready/in_data       restore stream
//   busy, done, err       status: busy level, end-of-command pulse, sticky error
//
// State table
//   S_IDLE     | waiting for cmd_start
//   S_RD_ADDR  | sst_addr presented to the mapper
//   S_RD_SMP   | mapper read data valid, captured at end of cycle
//   S_OUT      | save byte offered on out_data until out_ready
//   S_CHK_WAIT | waiting for a host byte (header check or data)
//   S_WR       | one-cycle write strobe to the mapper
//   S_FIN      | done pulse, then back to idle
// -----------------------------------------------------------------------------
module sst_engine (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_start,
  input  logic       cmd_dir,
  output logic       sst_act,
  output logic [7:0] sst_addr,
  output logic       sst_we,
  output logic [7:0] sst_do,
  input  logic [7:0] sst_di,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam logic [6:0] ADDR_IDX  = 7'd127;
  localparam logic [6:0] ADDR_LAST = 7'd126;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ADDR,
    S_RD_SMP,
    S_OUT,
    S_CHK_WAIT,
    S_WR,
    S_FIN
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [6:0] r_addr;
  logic       r_dir;
  logic [7:0] r_rd_data;
  logic [7:0] r_wr_data;
  logic       r_err;

  logic       w_start;
  logic       w_out_hs;
  logic       w_in_hs;
  logic       w_hdr;
  logic       w_hdr_bad;
  logic [6:0] w_addr_nxt;

  assign w_start   = (r_state == S_IDLE) && cmd_start;
  assign w_out_hs  = (r_state == S_OUT) && out_ready;
  assign w_in_hs   = (r_state == S_CHK_WAIT) && in_valid;
  // Address 127 is only ever held during the header phase, so it doubles as
  // the "header not yet handled" marker.
  assign w_hdr     = (r_addr == ADDR_IDX);
  assign w_hdr_bad = w_hdr && (in_data != r_rd_data);
  // After the header the stream continues at 0; this is a deliberate jump,
  // not a 7-bit wrap.
  assign w_addr_nxt = w_hdr ? 7'd0 : (r_addr + 7'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    sst_act     = 1'b0;
    busy        = 1'b0;
    sst_we      = 1'b0;
    out_valid   = 1'b0;
    in_ready    = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cmd_start) w_state_nxt = S_RD_ADDR;
      end
      S_RD_ADDR: begin
        busy        = 1'b1;
        sst_act     = 1'b1;
        w_state_nxt = S_RD_SMP;
      end
      S_RD_SMP: begin
        busy        = 1'b1;
        sst_act     = 1'b1;
        w_state_nxt = r_dir ? S_CHK_WAIT : S_OUT;
      end
      S_OUT: begin
        busy      = 1'b1;
        sst_act   = 1'b1;
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = (r_addr == ADDR_LAST) ? S_FIN : S_RD_ADDR;
      end
      S_CHK_WAIT: begin
        busy     = 1'b1;
        sst_act  = 1'b1;
        in_ready = 1'b1;
        if (in_valid) begin
          if (!w_hdr)         w_state_nxt = S_WR;
          else if (w_hdr_bad) w_state_nxt = S_FIN;
        end
      end
      S_WR: begin
        busy        = 1'b1;
        sst_act     = 1'b1;
        sst_we      = 1'b1;
        w_state_nxt = (r_addr == ADDR_LAST) ? S_FIN : S_CHK_WAIT;
      end
      S_FIN: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr    <= 7'd0;
      r_dir     <= 1'b0;
      r_rd_data <= 8'd0;
      r_wr_data <= 8'd0;
      r_err     <= 1'b0;
    end else begin
      if (w_start) begin
        r_addr <= ADDR_IDX;
        r_dir  <= cmd_dir;
        r_err  <= 1'b0;
      end
      if (r_state == S_RD_SMP) r_rd_data <= sst_di;
      if (w_out_hs && (r_addr != ADDR_LAST)) r_addr <= w_addr_nxt;
      if (w_in_hs) begin
        if (w_hdr) begin
          if (w_hdr_bad) r_err  <= 1'b1;
          else           r_addr <= w_addr_nxt;
        end else begin
          r_wr_data <= in_data;
        end
      end
      if ((r_state == S_WR) && (r_addr != ADDR_LAST)) r_addr <= w_addr_nxt;
    end
  end

  assign sst_addr = {1'b0, r_addr};
  assign sst_do   = r_wr_data;
  assign out_data = r_rd_data;
  assign err      = r_err;

endmodule

// File: tb/tb_sst_engine.sv
`timescale 1ns/1ps
// Directed bench for sst_engine with a behavioural mapper model and
// queue-based scoreboards for the save stream and the mapper writes.
module tb_sst_engine;

  logic       clk;
  logic       rst_n;
  logic       cmd_start;
  logic       cmd_dir;
  logic       sst_act;
  logic [7:0] sst_addr;
  logic       sst_we;
  logic [7:0] sst_do;
  logic [7:0] sst_di;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       busy;
  logic       done;
  logic       err;

  int n_checks = 0;
  int n_fail   = 0;
  int n_we     = 0;
  int n_done   = 0;
  int n_out_acc = 0;
  int n_in_acc  = 0;

  logic [7:0]  exp_q[$];
  logic [15:0] wr_q[$];

  sst_engine dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_start (cmd_start),
    .cmd_dir   (cmd_dir),
    .sst_act   (sst_act),
    .sst_addr  (sst_addr),
    .sst_we    (sst_we),
    .sst_do    (sst_do),
    .sst_di    (sst_di),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Mapper: index 0xC0 at 127, k^5A for 0..126, FF above; one-cycle read.
  always @(posedge clk) begin
    if (sst_addr == 8'd127)     sst_di <= 8'hC0;
    else if (sst_addr < 8'd127) sst_di <= sst_addr ^ 8'h5A;
    else                        sst_di <= 8'hFF;
  end

  function automatic void check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endfunction

  // Monitor, sampled on the falling edge.
  initial begin
    logic       prev_stall;
    logic [7:0] prev_data;
    logic       prev_we;
    logic [7:0] e8;
    logic [15:0] e16;
    prev_stall = 1'b0;
    prev_data  = 8'd0;
    prev_we    = 1'b0;
    forever begin
      @(negedge clk);
      if (done === 1'b1) n_done++;
      if (out_valid && out_ready) begin
        n_out_acc++;
        check("save_byte_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e8 = exp_q.pop_front();
          check("save_byte", 32'(out_data), 32'(e8));
        end
      end
      if (sst_we === 1'b1) begin
        n_we++;
        check("write_expected", 32'(wr_q.size() != 0), 32'd1);
        check("write_addr_below_127", 32'(sst_addr < 8'd127), 32'd1);
        if (wr_q.size() != 0) begin
          e16 = wr_q.pop_front();
          check("write_addr_data", 32'({sst_addr, sst_do}), 32'(e16));
        end
      end
      if (prev_we) check("we_single_cycle", 32'(sst_we), 32'd0);
      if (in_valid && in_ready) n_in_acc++;
      if (in_ready || out_valid) check("in_ready_out_valid_excl", 32'(in_ready & out_valid), 32'd0);
      if (prev_stall) begin
        check("out_valid_held", 32'(out_valid), 32'd1);
        check("out_data_stable", 32'(out_data), 32'(prev_data));
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_we    = sst_we;
    end
  end

  task automatic clear_counts();
    n_we = 0; n_done = 0; n_out_acc = 0; n_in_acc = 0;
  endtask

  task automatic push_save_expect();
    for (int j = 0; j < 128; j++) begin
      if (j == 0) exp_q.push_back(8'hC0);
      else        exp_q.push_back(8'(j - 1) ^ 8'h5A);
    end
  endtask

  task automatic push_restore_expect();
    for (int k = 0; k < 127; k++) wr_q.push_back({8'(k), 8'(8'h80 + k)});
  endtask

  task automatic start_cmd(input logic dir);
    cmd_start = 1'b1;
    cmd_dir   = dir;
    @(posedge clk); #1;
    cmd_start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    check("act_after_start", 32'(sst_act), 32'd1);
    check("err_clear_on_start", 32'(err), 32'd0);
  endtask

  task automatic run_save(input bit rnd, input int spurious_at);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      cmd_start = (c == spurious_at);
      cmd_dir   = 1'b1;
      @(posedge clk); #1;
      cmd_start = 1'b0;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check("save_done_seen", 32'(seen), 32'd1);
    check("busy_low_in_fin", 32'(busy), 32'd0);
    out_ready = 1'b0;
    cmd_dir   = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic run_restore(input logic [7:0] hdr, input int abort_at);
    int idx;
    bit hs;
    bit seen;
    idx  = 0;
    seen = 1'b0;
    in_valid = 1'b1;
    in_data  = hdr;
    hs = in_valid && in_ready;
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      if (hs) begin
        idx++;
        if (idx < 128) in_data = 8'(8'h80 + idx - 1);
        else           in_valid = 1'b0;
      end
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (abort_at > 0 && n_we >= abort_at) break;
      hs = in_valid && in_ready;
    end
    if (abort_at == 0) begin
      check("restore_done_seen", 32'(seen), 32'd1);
      check("restore_busy_low_in_fin", 32'(busy), 32'd0);
      repeat (3) begin
        @(posedge clk); #1;
      end
      in_valid = 1'b0;
    end
  endtask

  task automatic end_checks(input string t, input int e_we, input int e_out,
                            input int e_in, input logic e_err);
    check({t, "_we_count"}, 32'(n_we), 32'(e_we));
    check({t, "_done_count"}, 32'(n_done), 32'd1);
    check({t, "_out_count"}, 32'(n_out_acc), 32'(e_out));
    check({t, "_in_count"}, 32'(n_in_acc), 32'(e_in));
    check({t, "_err"}, 32'(err), 32'(e_err));
    check({t, "_save_q_empty"}, 32'(exp_q.size()), 32'd0);
    check({t, "_write_q_empty"}, 32'(wr_q.size()), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; cmd_start = 1'b0; cmd_dir = 1'b0;
    out_ready = 1'b0; in_valid = 1'b0; in_data = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 32'({sst_act, sst_we, out_valid, in_ready, busy, done, err,
                                sst_addr, sst_do, out_data}), 32'd0);
    rst_n = 1'b1;

    // Save with out_ready held high; command issued right after reset release.
    clear_counts();
    push_save_expect();
    start_cmd(1'b0);
    run_save(1'b0, -1);
    end_checks("save_fast", 0, 128, 0, 1'b0);

    // Save with random backpressure and a stray cmd_start while busy.
    clear_counts();
    push_save_expect();
    start_cmd(1'b0);
    run_save(1'b1, 30);
    end_checks("save_rand", 0, 128, 0, 1'b0);

    // Restore with matching header.
    clear_counts();
    push_restore_expect();
    start_cmd(1'b1);
    run_restore(8'hC0, 0);
    end_checks("restore_ok", 127, 0, 128, 1'b0);

    // Restore with wrong header: error, no writes, only the header accepted.
    clear_counts();
    start_cmd(1'b1);
    run_restore(8'h4A, 0);
    end_checks("restore_bad", 0, 0, 1, 1'b1);
    check("err_sticky_idle", 32'(err), 32'd1);
    check("in_ready_idle", 32'(in_ready), 32'd0);

    // Reset after 10 restore writes.
    clear_counts();
    push_restore_expect();
    start_cmd(1'b1);
    run_restore(8'hC0, 10);
    rst_n = 1'b0;
    #1;
    check("midop_reset_outputs", 32'({sst_act, sst_we, out_valid, in_ready, busy, done, err,
                                      sst_addr, sst_do, out_data}), 32'd0);
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("abort_we_count", 32'(n_we), 32'd10);
    check("abort_done_count", 32'(n_done), 32'd0);
    wr_q.delete();
    rst_n = 1'b1;

    // Save immediately after release.
    clear_counts();
    push_save_expect();
    start_cmd(1'b0);
    run_save(1'b0, -1);
    end_checks("save_after_reset", 0, 128, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
